// File: rtl/t2mi_pkg.sv
// t2mi_pkg
// Shared definitions for the T2-MI frame scheduler:
//   - packet-type codes placed in the T2-MI packet header
//   - scheduler FSM state encoding
//   - configuration validity check used at START and at superframe wrap
// Build option: T2MI_TIMESTAMP_EN adds the timestamp-grant state.
package t2mi_pkg;

    localparam logic [7:0] PKT_BB        = 8'h00;
    localparam logic [7:0] PKT_L1_CUR    = 8'h10;
    localparam logic [7:0] PKT_TIMESTAMP = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
`ifdef T2MI_TIMESTAMP_EN
        ST_TSP       = 3'd1,
`endif
        ST_L1        = 3'd2,
        ST_BB_WAIT   = 3'd3,
        ST_BB_GNT    = 3'd4,
        ST_FRAME_END = 3'd5
    } sched_state_t;

    // A configuration is usable only with at least one BB frame per T2 frame,
    // at least one T2 frame per superframe, and a block count within bounds.
    function automatic logic cfg_valid(
        input logic [9:0]  blocks,
        input logic [7:0]  frames,
        input logic [31:0] max_blocks
    );
        return (blocks != 10'd0) && (frames != 8'd0) &&
               ({22'd0, blocks} <= max_blocks);
    endfunction

endpackage

// File: rtl/t2mi_frame_counter.sv
// t2mi_frame_counter
// Frame and superframe index counters for the T2-MI packet headers.
// Ports:
//   clk, rst        byte clock, synchronous active-high reset
//   advance         one-cycle strobe: the current T2 frame has ended
//   num_frames      latched T2 frames per superframe (non-zero while running)
//   frame_idx       registered T2 frame index within the superframe
//   sf_idx          registered superframe index, wraps at 2^SF_IDX_W
//   wrap            combinational strobe: this advance closes the superframe,
//                   used by the scheduler to re-latch its configuration
module t2mi_frame_counter #(
    parameter int SF_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    input  logic [7:0]          num_frames,
    output logic [7:0]          frame_idx,
    output logic [SF_IDX_W-1:0] sf_idx,
    output logic                wrap
);

    logic [7:0]          frame_idx_r;
    logic [SF_IDX_W-1:0] sf_idx_r;

    // Superframe closes when the last frame of the latched count ends.
    always_comb begin
        if (advance && (frame_idx_r == (num_frames - 8'd1))) begin
            wrap = 1'b1;
        end else begin
            wrap = 1'b0;
        end
    end

    // Index registers: step the frame index, roll into the superframe index.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_idx_r <= 8'd0;
            sf_idx_r    <= '0;
        end else if (advance) begin
            if (wrap) begin
                frame_idx_r <= 8'd0;
                sf_idx_r    <= sf_idx_r + SF_IDX_W'(1);
            end else begin
                frame_idx_r <= frame_idx_r + 8'd1;
            end
        end
    end

    assign frame_idx = frame_idx_r;
    assign sf_idx    = sf_idx_r;

endmodule

// File: rtl/t2mi_frame_scheduler.sv
// t2mi_frame_scheduler
// Grants the shared T2-MI packet-assembly path once per T2 frame, in order:
// timestamp (optional), L1-current, then plp_num_blocks BB frames.
// Build option: T2MI_TIMESTAMP_EN. When undefined there is no timestamp
// grant, TSP_GNT is tied low, TSP_DONE is ignored and frames start at L1.
// Ports:
//   CLK, RST                  byte clock, synchronous active-high reset
//   START                     pulse: TS sync acquired, begin scheduling
//   plp_num_blocks            BB frames per T2 frame (latched)
//   num_t2_frames             T2 frames per superframe (latched)
//   BB_READY                  BB generator holds a complete BB frame
//   BB_DONE/L1_DONE/TSP_DONE  granted generator finished its packet
//   BB_GNT/L1_GNT/TSP_GNT     grants, at most one high
//   PKT_TYPE                  type code of the granted packet
//   FRAME_IDX, SF_IDX         header frame / superframe indices
//   FRAME_PULSE               one-cycle pulse at each frame end
//   BUSY                      scheduler not idle
//   CFG_ERR                   sticky invalid-configuration flag
module t2mi_frame_scheduler
    import t2mi_pkg::*;
#(
    parameter int MAX_BLOCKS = 1023,
    parameter int SF_IDX_W   = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [9:0]          plp_num_blocks,
    input  logic [7:0]          num_t2_frames,
    input  logic                BB_READY,
    input  logic                BB_DONE,
    input  logic                L1_DONE,
    input  logic                TSP_DONE,
    output logic                BB_GNT,
    output logic                L1_GNT,
    output logic                TSP_GNT,
    output logic [7:0]          PKT_TYPE,
    output logic [7:0]          FRAME_IDX,
    output logic [SF_IDX_W-1:0] SF_IDX,
    output logic                FRAME_PULSE,
    output logic                BUSY,
    output logic                CFG_ERR
);

    sched_state_t state_r;
    logic [9:0]   blk_cnt_r;
    logic [9:0]   num_blocks_r;
    logic [7:0]   num_frames_r;
    logic         bb_gnt_r;
    logic         l1_gnt_r;
    logic [7:0]   pkt_type_r;
    logic         frame_pulse_r;
    logic         busy_r;
    logic         cfg_err_r;
    logic         last_blk_s;
    logic         advance_s;
    logic         wrap_s;
`ifdef T2MI_TIMESTAMP_EN
    logic         tsp_gnt_r;
`else
    logic         tsp_done_unused_s;
`endif

    // Frame ends on the BB_DONE of the last BB frame of the latched count.
    always_comb begin
        last_blk_s = (blk_cnt_r == (num_blocks_r - 10'd1));
        if ((state_r == ST_BB_GNT) && BB_DONE) begin
            advance_s = last_blk_s;
        end else begin
            advance_s = 1'b0;
        end
    end

    t2mi_frame_counter #(
        .SF_IDX_W   (SF_IDX_W)
    ) u_frame_counter (
        .clk        (CLK),
        .rst        (RST),
        .advance    (advance_s),
        .num_frames (num_frames_r),
        .frame_idx  (FRAME_IDX),
        .sf_idx     (SF_IDX),
        .wrap       (wrap_s)
    );

    // Scheduler FSM with registered grants, packet type and status flags.
    // Grants only ever rise on an edge where every grant is already low,
    // which guarantees the idle cycle between consecutive grants.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            blk_cnt_r     <= 10'd0;
            num_blocks_r  <= 10'd0;
            num_frames_r  <= 8'd0;
            bb_gnt_r      <= 1'b0;
            l1_gnt_r      <= 1'b0;
`ifdef T2MI_TIMESTAMP_EN
            tsp_gnt_r     <= 1'b0;
`endif
            pkt_type_r    <= PKT_BB;
            frame_pulse_r <= 1'b0;
            busy_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            frame_pulse_r <= 1'b0;
            // Superframe boundary: pick up whatever config is presented now.
            if (wrap_s) begin
                num_blocks_r <= plp_num_blocks;
                num_frames_r <= num_t2_frames;
            end
            case (state_r)
                ST_IDLE: begin
                    if (START && !cfg_err_r) begin
                        num_blocks_r <= plp_num_blocks;
                        num_frames_r <= num_t2_frames;
                        if (cfg_valid(plp_num_blocks, num_t2_frames, 32'(MAX_BLOCKS))) begin
                            busy_r <= 1'b1;
`ifdef T2MI_TIMESTAMP_EN
                            state_r    <= ST_TSP;
                            tsp_gnt_r  <= 1'b1;
                            pkt_type_r <= PKT_TIMESTAMP;
`else
                            state_r    <= ST_L1;
                            l1_gnt_r   <= 1'b1;
                            pkt_type_r <= PKT_L1_CUR;
`endif
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                end
`ifdef T2MI_TIMESTAMP_EN
                ST_TSP: begin
                    if (TSP_DONE) begin
                        tsp_gnt_r <= 1'b0;
                        state_r   <= ST_L1;
                    end
                end
`endif
                ST_L1: begin
                    // Entered with the grant low after a timestamp packet;
                    // the first cycle here is the inter-grant gap.
                    if (!l1_gnt_r) begin
                        l1_gnt_r   <= 1'b1;
                        pkt_type_r <= PKT_L1_CUR;
                    end else if (L1_DONE) begin
                        l1_gnt_r <= 1'b0;
                        state_r  <= ST_BB_WAIT;
                    end
                end
                ST_BB_WAIT: begin
                    if (BB_READY) begin
                        bb_gnt_r   <= 1'b1;
                        pkt_type_r <= PKT_BB;
                        state_r    <= ST_BB_GNT;
                    end
                end
                ST_BB_GNT: begin
                    if (BB_DONE) begin
                        bb_gnt_r <= 1'b0;
                        if (last_blk_s) begin
                            blk_cnt_r     <= 10'd0;
                            frame_pulse_r <= 1'b1;
                            state_r       <= ST_FRAME_END;
                        end else begin
                            blk_cnt_r <= blk_cnt_r + 10'd1;
                            state_r   <= ST_BB_WAIT;
                        end
                    end
                end
                ST_FRAME_END: begin
                    // Config may have been re-latched on the edge that got us here.
                    if (!cfg_valid(num_blocks_r, num_frames_r, 32'(MAX_BLOCKS))) begin
                        cfg_err_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
`ifdef T2MI_TIMESTAMP_EN
                        state_r    <= ST_TSP;
                        tsp_gnt_r  <= 1'b1;
                        pkt_type_r <= PKT_TIMESTAMP;
`else
                        state_r    <= ST_L1;
                        l1_gnt_r   <= 1'b1;
                        pkt_type_r <= PKT_L1_CUR;
`endif
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    bb_gnt_r <= 1'b0;
                    l1_gnt_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef T2MI_TIMESTAMP_EN
    assign TSP_GNT = tsp_gnt_r;
`else
    assign TSP_GNT           = 1'b0;
    assign tsp_done_unused_s = TSP_DONE;
`endif
    assign BB_GNT      = bb_gnt_r;
    assign L1_GNT      = l1_gnt_r;
    assign PKT_TYPE    = pkt_type_r;
    assign FRAME_PULSE = frame_pulse_r;
    assign BUSY        = busy_r;
    assign CFG_ERR     = cfg_err_r;

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// tb_t2mi_frame_scheduler
// Directed bench for t2mi_frame_scheduler with a slot-based reference model.
// Works in both builds (T2MI_TIMESTAMP_EN defined or not).
module tb_t2mi_frame_scheduler;

`ifdef T2MI_TIMESTAMP_EN
    localparam int TS = 1;
`else
    localparam int TS = 0;
`endif
    localparam int SFW = 4;

    logic           CLK;
    logic           RST;
    logic           START;
    logic [9:0]     plp_num_blocks;
    logic [7:0]     num_t2_frames;
    logic           BB_READY;
    logic           BB_DONE;
    logic           L1_DONE;
    logic           TSP_DONE;
    logic           BB_GNT;
    logic           L1_GNT;
    logic           TSP_GNT;
    logic [7:0]     PKT_TYPE;
    logic [7:0]     FRAME_IDX;
    logic [SFW-1:0] SF_IDX;
    logic           FRAME_PULSE;
    logic           BUSY;
    logic           CFG_ERR;

    t2mi_frame_scheduler #(
        .MAX_BLOCKS     (1023),
        .SF_IDX_W       (SFW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .plp_num_blocks (plp_num_blocks),
        .num_t2_frames  (num_t2_frames),
        .BB_READY       (BB_READY),
        .BB_DONE        (BB_DONE),
        .L1_DONE        (L1_DONE),
        .TSP_DONE       (TSP_DONE),
        .BB_GNT         (BB_GNT),
        .L1_GNT         (L1_GNT),
        .TSP_GNT        (TSP_GNT),
        .PKT_TYPE       (PKT_TYPE),
        .FRAME_IDX      (FRAME_IDX),
        .SF_IDX         (SF_IDX),
        .FRAME_PULSE    (FRAME_PULSE),
        .BUSY           (BUSY),
        .CFG_ERR        (CFG_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a list of packet slots: TS timestamp slots, one L1 slot,
    // then m_nb BB slots. The model tracks which slot is being served and
    // whether its grant is currently up.
    bit m_run, m_err, m_on, m_fend, m_pulse;
    int m_slot, m_fidx, m_sf, m_nb, m_nf;

    function automatic int slot_kind(input int s);   // 1 TSP, 2 L1, 3 BB
        if (s < TS) return 1;
        else if (s == TS) return 2;
        else return 3;
    endfunction

    function automatic int ptype_of(input int k);
        if (k == 1) return 32;
        else if (k == 2) return 16;
        else return 0;
    endfunction

    function automatic bit cfg_ok(input int nb, input int nf);
        return (nb > 0) && (nf > 0) && (nb <= 1023);
    endfunction

    task automatic model_step();
        int k;
        bit d;
        m_pulse = 1'b0;
        if (RST) begin
            m_run = 0; m_err = 0; m_on = 0; m_fend = 0;
            m_slot = 0; m_fidx = 0; m_sf = 0;
        end else if (!m_run) begin
            if (START && !m_err) begin
                m_nb = int'(plp_num_blocks);
                m_nf = int'(num_t2_frames);
                if (cfg_ok(m_nb, m_nf)) begin
                    m_run = 1; m_slot = 0; m_on = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_fend) begin
            m_fend = 0;
            if (cfg_ok(m_nb, m_nf)) begin
                m_slot = 0; m_on = 1;
            end else begin
                m_run = 0; m_err = 1;
            end
        end else if (m_on) begin
            k = slot_kind(m_slot);
            d = (k == 1) ? TSP_DONE : ((k == 2) ? L1_DONE : BB_DONE);
            if (d) begin
                m_on = 0;
                m_slot++;
                if (m_slot == TS + 1 + m_nb) begin
                    m_fend = 1; m_pulse = 1; m_slot = 0;
                    if (m_fidx == m_nf - 1) begin
                        m_fidx = 0;
                        m_sf   = (m_sf + 1) % (1 << SFW);
                        m_nb   = int'(plp_num_blocks);
                        m_nf   = int'(num_t2_frames);
                    end else begin
                        m_fidx++;
                    end
                end
            end
        end else begin
            // Gap cycle: non-BB slots always follow; BB waits for a ready frame.
            if (slot_kind(m_slot) != 3 || BB_READY) m_on = 1;
        end
    endtask

    always @(posedge CLK) model_step();

    int cmp_kind;
    // Per-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp_kind = m_on ? slot_kind(m_slot) : 0;
            chk("tsp_gnt", int'(TSP_GNT), int'(cmp_kind == 1));
            chk("l1_gnt", int'(L1_GNT), int'(cmp_kind == 2));
            chk("bb_gnt", int'(BB_GNT), int'(cmp_kind == 3));
            if (cmp_kind != 0) chk("pkt_type", int'(PKT_TYPE), ptype_of(cmp_kind));
            chk("frame_idx", int'(FRAME_IDX), m_fidx);
            chk("sf_idx", int'(SF_IDX), m_sf);
            chk("frame_pulse", int'(FRAME_PULSE), int'(m_pulse));
            chk("busy", int'(BUSY), int'(m_run));
            chk("cfg_err", int'(CFG_ERR), int'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    int seq[$];
    int prev_kind  = 0;
    int age        = 0;
    int pulses     = 0;
    int done_delay = 1;
    bit inject_bad = 1'b0;

    // One cycle: generators answer their grant with DONE after done_delay cycles.
    task automatic tick();
        int cur;
        @(negedge CLK);
        START = 1'b0; TSP_DONE = 1'b0; L1_DONE = 1'b0; BB_DONE = 1'b0;
        if (FRAME_PULSE) pulses++;
        cur = TSP_GNT ? 1 : (L1_GNT ? 2 : (BB_GNT ? 3 : 0));
        if (cur != 0 && cur != prev_kind) seq.push_back(cur);
        prev_kind = cur;
        if (cur != 0) age++; else age = 0;
        if (cur != 0 && age > done_delay) begin
            if (cur == 1) TSP_DONE = 1'b1;
            else if (cur == 2) L1_DONE = 1'b1;
            else BB_DONE = 1'b1;
        end
        if (inject_bad && cur == 3 && age == 1) begin
            L1_DONE = 1'b1; TSP_DONE = 1'b1;
        end
    endtask

    task automatic run_until_pulses(input int n, input int budget);
        int target;
        target = pulses + n;
        for (int i = 0; i < budget && pulses < target; i++) tick();
        chk("frame_pulse_timeout", pulses, target);
    endtask

    // mode 0: L1 grant up; mode 1: BB grant up in frame 1
    task automatic wait_cond(input int mode, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            if (mode == 0) hit = L1_GNT;
            else hit = BB_GNT && (FRAME_IDX == 8'd1);
        end
        chk("wait_timeout", int'(hit), 1);
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_tsp"}, int'(TSP_GNT), 0);
        chk({name, "_l1"}, int'(L1_GNT), 0);
        chk({name, "_bb"}, int'(BB_GNT), 0);
        chk({name, "_pkt"}, int'(PKT_TYPE), 0);
        chk({name, "_fidx"}, int'(FRAME_IDX), 0);
        chk({name, "_sf"}, int'(SF_IDX), 0);
        chk({name, "_pulse"}, int'(FRAME_PULSE), 0);
        chk({name, "_busy"}, int'(BUSY), 0);
        chk({name, "_err"}, int'(CFG_ERR), 0);
    endtask

    // Grant order for a 3-block frame: [TSP,] L1, BB, BB, BB
    task automatic check_seq(input string name);
        int exp_q[$];
        for (int i = 0; i < TS; i++) exp_q.push_back(1);
        exp_q.push_back(2);
        for (int i = 0; i < 3; i++) exp_q.push_back(3);
        chk({name, "_len"}, seq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seq.size(); i++) chk(name, seq[i], exp_q[i]);
    endtask

    int bb_seen;

    initial begin
        RST = 1'b1; START = 1'b0; BB_READY = 1'b1;
        TSP_DONE = 1'b0; L1_DONE = 1'b0; BB_DONE = 1'b0;
        plp_num_blocks = 10'd3; num_t2_frames = 8'd2;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        RST = 1'b0;
        reset_checks("reset");

        // Superframe of 2 frames, config change mid-superframe ignored.
        seq.delete();
        START = 1'b1; tick(); tick();
        num_t2_frames = 8'd4;
        run_until_pulses(1, 200);
        check_seq("seq_frame0");
        chk("fidx_after_f0", int'(FRAME_IDX), 1);
        chk("sf_after_f0", int'(SF_IDX), 0);

        // Stray DONEs during BB grants and START while busy.
        seq.delete();
        inject_bad = 1'b1;
        tick(); tick(); tick();
        START = 1'b1; tick();
        run_until_pulses(1, 200);
        inject_bad = 1'b0;
        check_seq("seq_frame1");
        chk("fidx_wrap", int'(FRAME_IDX), 0);
        chk("sf_wrap", int'(SF_IDX), 1);

        // Next superframe uses the re-latched 4 frames.
        run_until_pulses(3, 600);
        chk("fidx_sf1_f3", int'(FRAME_IDX), 3);
        chk("sf_sf1_f3", int'(SF_IDX), 1);
        run_until_pulses(1, 200);
        chk("fidx_sf2", int'(FRAME_IDX), 0);
        chk("sf_sf2", int'(SF_IDX), 2);

        // BB_READY low through a long BB_WAIT.
        wait_cond(0, 200);
        BB_READY = 1'b0;
        bb_seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (BB_GNT) bb_seen++;
        end
        chk("bb_gnt_not_ready", bb_seen, 0);
        BB_READY = 1'b1;
        tick();
        chk("bb_gnt_after_ready", int'(BB_GNT), 1);

        // Reset in the middle of a BB grant in frame 1.
        wait_cond(1, 400);
        RST = 1'b1; tick();
        RST = 1'b0;
        reset_checks("mid_rst");
        plp_num_blocks = 10'd3; num_t2_frames = 8'd2;
        START = 1'b1; tick();
        chk("restart_first_gnt", int'(TS ? TSP_GNT : L1_GNT), 1);
        chk("restart_fidx", int'(FRAME_IDX), 0);

        // Superframe index wrap with 1 block, 1 frame per superframe.
        RST = 1'b1; tick();
        RST = 1'b0;
        plp_num_blocks = 10'd1; num_t2_frames = 8'd1;
        START = 1'b1; tick();
        run_until_pulses(15, 1500);
        chk("sf_15", int'(SF_IDX), 15);
        run_until_pulses(1, 100);
        chk("sf_wrap_0", int'(SF_IDX), 0);
        chk("fidx_1frame", int'(FRAME_IDX), 0);

        // Invalid config at START, sticky until reset.
        RST = 1'b1; tick();
        RST = 1'b0;
        plp_num_blocks = 10'd0; num_t2_frames = 8'd2;
        START = 1'b1; tick();
        chk("cfg0_err", int'(CFG_ERR), 1);
        chk("cfg0_busy", int'(BUSY), 0);
        plp_num_blocks = 10'd3;
        START = 1'b1; tick(); tick(); tick();
        chk("cfg0_restart_busy", int'(BUSY), 0);
        chk("cfg0_restart_gnt", int'(L1_GNT | TSP_GNT | BB_GNT), 0);
        RST = 1'b1; tick();
        RST = 1'b0;
        chk("cfg_err_cleared", int'(CFG_ERR), 0);
        num_t2_frames = 8'd0;
        START = 1'b1; tick();
        chk("nfr0_err", int'(CFG_ERR), 1);

        // Invalid block count picked up at superframe wrap.
        RST = 1'b1; tick();
        RST = 1'b0;
        plp_num_blocks = 10'd2; num_t2_frames = 8'd1;
        START = 1'b1; tick(); tick();
        plp_num_blocks = 10'd0;
        run_until_pulses(1, 200);
        tick();
        chk("relatch_err", int'(CFG_ERR), 1);
        chk("relatch_busy", int'(BUSY), 0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t2mi_frame_scheduler.md
# t2mi_frame_scheduler

Sequences T2-MI packet generation per T2 frame. It grants the shared packet-assembly path, in a fixed order, to the timestamp generator, the L1-current generator and the BB-frame generator. It tracks frame and superframe indices for the packet headers. It sits between the parameter block and the TS-to-T2-MI packetizer, driven by the same byte clock as the rest of the packer.

## Interface
Parameters:
- `MAX_BLOCKS`, default 1023: upper bound accepted for `plp_num_blocks`.
- `SF_IDX_W`, default 4: width of the superframe index counter.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: byte clock, shared with the TS/T2-MI datapath.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle pulse, input TS sync acquired; begins scheduling.
- `plp_num_blocks` in 10: BB frames per T2 frame.
- `num_t2_frames` in 8: T2 frames per superframe.
- `BB_READY` in 1: BB-frame generator holds a complete BB frame.
- `BB_DONE`, `L1_DONE`, `TSP_DONE` in 1 each: granted generator finished its packet.
- `BB_GNT`, `L1_GNT`, `TSP_GNT` out 1 each: grants; at most one is high.
- `PKT_TYPE` out 8: type of the granted packet. 8'h00 BB, 8'h10 L1-current, 8'h20 timestamp.
- `FRAME_IDX` out 8: current T2 frame index.
- `SF_IDX` out `SF_IDX_W`: current superframe index.
- `FRAME_PULSE` out 1: one-cycle pulse at each frame end.
- `BUSY` out 1: scheduler is active (not IDLE).
- `CFG_ERR` out 1: latched config invalid; sticky until RST.

## Operation
FSM states and transitions:
- IDLE: waits for `START`. On `START`, latch config and go to TSP_GNT, or to L1_GNT when `T2MI_TIMESTAMP_EN` is undefined.
- TSP_GNT: `TSP_GNT`=1, `PKT_TYPE`=8'h20. Hold until `TSP_DONE`, then go to L1_GNT.
- L1_GNT: `L1_GNT`=1, `PKT_TYPE`=8'h10. Hold until `L1_DONE`, then go to BB_WAIT.
- BB_WAIT: hold until `BB_READY`, then go to BB_GNT.
- BB_GNT: `BB_GNT`=1, `PKT_TYPE`=8'h00. On `BB_DONE`, `blk_cnt`++. If `blk_cnt`==latched `plp_num_blocks`-1, go to FRAME_END; else go to BB_WAIT.
- FRAME_END: lasts one cycle. Assert `FRAME_PULSE`, clear `blk_cnt`, and advance `FRAME_IDX`.
  - When `FRAME_IDX`==`num_t2_frames`-1, wrap `FRAME_IDX` to 0, increment `SF_IDX` (wraps 2^`SF_IDX_W`-1 -> 0), and re-latch config.
  - Then go to TSP_GNT or L1_GNT.

Config rules:
- `plp_num_blocks` and `num_t2_frames` are latched only at `START` and at superframe wrap. Mid-superframe input changes have no effect.
- Latched `plp_num_blocks`==0, `num_t2_frames`==0, or `plp_num_blocks`>`MAX_BLOCKS`: set `CFG_ERR`, go to IDLE, clear all grants. `START` is ignored while `CFG_ERR`=1.

Boundary conditions:
- `START` while `BUSY`=1 is ignored.
- A `*_DONE` is honoured only when its own grant is high. A DONE without its grant, or a mismatched DONE, is ignored.
- `blk_cnt` is 10-bit unsigned and never exceeds latched `plp_num_blocks`-1.
- `RST` mid-packet: at the next edge all outputs return to reset values, counters clear, and any pending DONE is lost.

## Timing
- Reset values: every grant 0, `PKT_TYPE`=8'h00, `FRAME_IDX`=0, `SF_IDX`=0, `FRAME_PULSE`=0, `BUSY`=0, `CFG_ERR`=0.
- All outputs are registered.
- A grant rises one cycle after the `START` or DONE edge that selects its state.
- The edge sampling `*_GNT`=1 and `*_DONE`=1 drops that grant. The next grant rises at the following edge, so there is exactly one idle cycle between grants.
- `BB_READY` already high in BB_WAIT: `BB_GNT` rises one cycle after entering BB_WAIT.
- `FRAME_PULSE`, `FRAME_IDX`, `SF_IDX` and the config re-latch all update on the same edge.
- `PKT_TYPE` is valid whenever any grant is high and is stable for the whole grant.

## Configuration
- `T2MI_TIMESTAMP_EN` defined: TSP_GNT state exists, and one timestamp packet is granted at the start of every T2 frame.
- `T2MI_TIMESTAMP_EN` undefined: TSP_GNT state is removed, `TSP_GNT` is tied 0, `TSP_DONE` is ignored, and each frame starts at L1_GNT.

## Structure
- Shared package `t2mi_pkg` holds:
  - packet-type constants `PKT_BB`=8'h00, `PKT_L1_CUR`=8'h10, `PKT_TIMESTAMP`=8'h20;
  - the FSM state enum;
  - the config-validity check function.
- Sub-module `t2mi_frame_counter` contains the `FRAME_IDX`/`SF_IDX` counters with wrap and re-latch strobe. Inputs: advance pulse, latched `num_t2_frames`.

## Test plan
- Timestamp enabled, `plp_num_blocks`=3, `num_t2_frames`=2, DONE one cycle after each grant, `BB_READY`=1 -> per frame: grants TSP, L1, BB, BB, BB. `FRAME_PULSE` after the 3rd `BB_DONE`. `FRAME_IDX` goes 0,1,0 and `SF_IDX` increments at the wrap.
- `BB_READY` low for 20 cycles in BB_WAIT -> `BB_GNT` stays 0 for all 20 cycles and rises one cycle after `BB_READY`.
- `num_t2_frames` changed from 2 to 4 during frame 0 -> wrap still occurs after frame 1; the next superframe runs 4 frames.
- `START` with `plp_num_blocks`=0 -> `CFG_ERR`=1, `BUSY`=0, no grant; a second `START` is ignored until `RST`.
- `L1_DONE` pulsed during `BB_GNT`, and `START` pulsed while busy -> both ignored; sequence and counters unchanged.
- `RST` asserted mid-`BB_GNT` at `FRAME_IDX`=1 -> next edge: all outputs at reset values; a new `START` begins at `FRAME_IDX`=0 with the TSP grant (L1 grant when `T2MI_TIMESTAMP_EN` is undefined).
